min_topk_tracker: RTL and testbench
===================================

MIN_TOPK_TRACKER -- requirements
Module: min_topk_tracker

Interface
REQ-001 SHALL have parameter IDX_W, default 16, candidate index width.
REQ-002 SHALL have parameter VAL_W, default 14, candidate cost/value width (unsigned).
REQ-003 SHALL have parameter K, default 4, number of best (lowest-value) entries retained, legal 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begin a new search; clears list.
REQ-007 SHALL have port in_valid  input  1  candidate present this cycle; no backpressure.
REQ-008 SHALL have port in_index  input  IDX_W  candidate index.
REQ-009 SHALL have port in_value  input  VAL_W  candidate cost.
REQ-010 SHALL have port in_last  input  1  qualifies in_valid; final candidate of search.
REQ-011 SHALL have port rd_sel  input  clog2(K)+1  rank to read, 0 = best.
REQ-012 SHALL have port rd_index  output  IDX_W  index at rank rd_sel.
REQ-013 SHALL have port rd_value  output  VAL_W  value at rank rd_sel.
REQ-014 SHALL have port best_index  output  IDX_W  rank-0 index.
REQ-015 SHALL have port best_valid  output  1  list holds at least one entry.
REQ-016 SHALL have port fill  output  clog2(K+1)  entries held, saturates at K.
REQ-017 SHALL have port new_best  output  1  one-cycle pulse: rank 0 replaced.
REQ-018 SHALL have port done  output  1  one-cycle pulse: search complete.

Function
REQ-019 SHALL implement FSM IDLE, SEARCH, DONE; IDLE->SEARCH on start; SEARCH->DONE on accepted in_last; DONE->SEARCH on start; start in SEARCH restarts SEARCH.
REQ-020 SHALL accept candidates only when state==SEARCH, in_valid=1, start=0; otherwise in_valid ignored.
REQ-021 SHALL keep K entries sorted ascending by value; insert position p = number of valid entries with value strictly less than in_value (ties: newer candidate ranks ahead of older, matching legacy <= behaviour).
REQ-022 SHALL shift entries at ranks >= p down one rank, dropping rank K-1 when full; if p==K candidate discarded with no state change.
REQ-023 SHALL make an accepted update visible on outputs exactly one cycle after the accepting edge.
REQ-024 SHALL assert new_best for one cycle coincident with the update when p==0 (including first entry of a search).
REQ-025 SHALL assert done for one cycle coincident with the in_last candidate's update, whether or not that candidate was inserted.
REQ-026 SHALL clear list (fill=0, values all-ones, indices 0) on start; start has priority over a same-cycle in_valid, which is dropped.
REQ-027 SHALL hold list unchanged in DONE and IDLE.
REQ-028 SHALL drive rd_index/rd_value combinationally from registers; rd_sel >= fill returns 0/0.
REQ-029 SHALL derive best_valid as fill!=0; all-ones values are legal candidates (no sentinel).

Reset
REQ-030 SHALL on rst: state IDLE, fill 0, entry values all-ones, indices 0, best_index 0, new_best 0, done 0, immediately and independent of clk.
REQ-031 SHALL treat rst mid-search as full abort; no done pulse.

Structure
REQ-032 SHALL place FSM state enum and default parameter constants in shared package min_tracker_pkg.
REQ-033 SHALL use one sub-module topk_insert_pos: combinational compare of in_value against K entries producing p.

Verification (K=4)
REQ-034 Reset asserted mid-cycle -> best_valid=0, fill=0, rd_value(0)=0, no clock needed.
REQ-035 start; values 50,30,70,30 idx 0..3, last on idx3 -> ranks idx3/30, idx1/30, idx0/50, idx2/70; new_best after idx0, idx1, idx3; done with idx3 update.
REQ-036 Full list {10,20,30,40}; feed 100 -> unchanged, no pulse; feed 5 idx9 -> {5,10,20,30}, new_best=1.
REQ-037 start during SEARCH with same-cycle in_valid -> fill=0 next cycle, candidate absent.
REQ-038 in_valid in DONE -> list unchanged; start then 1 candidate -> fill=1.
REQ-039 K=1 build: sequence 9,4,4,7 -> best idx of second 4, new_best three times.

Source files
------------

// File: rtl/min_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | min_tracker_pkg : shared FSM encoding and default widths             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package min_tracker_pkg;

  localparam int c_DEFAULT_IDX_W = 16;
  localparam int c_DEFAULT_VAL_W = 14;
  localparam int c_DEFAULT_K     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } trackerState_t;

endpackage
`default_nettype wire

// File: rtl/topk_insert_pos.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | topk_insert_pos : rank at which a candidate lands in the sorted list |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module topk_insert_pos #(
  parameter int VAL_W = min_tracker_pkg::c_DEFAULT_VAL_W,
  parameter int K     = min_tracker_pkg::c_DEFAULT_K
) (
  input  logic [K*VAL_W-1:0]       entryValues,
  input  logic [$clog2(K+1)-1:0]   fill,
  input  logic [VAL_W-1:0]         candValue,
  output logic [$clog2(K+1)-1:0]   insPos
);

  localparam int POS_W = $clog2(K+1);

  // Strict less-than so an equal-valued newcomer lands ahead of older entries.
  always_comb begin
    insPos = '0;
    for (int i = 0; i < K; i++) begin
      if ((POS_W'(i) < fill) && (entryValues[i*VAL_W +: VAL_W] < candValue)) begin
        insPos = insPos + POS_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/min_topk_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | min_topk_tracker : keeps the K lowest-cost candidates of a search     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module min_topk_tracker #(
  parameter int IDX_W = min_tracker_pkg::c_DEFAULT_IDX_W,
  parameter int VAL_W = min_tracker_pkg::c_DEFAULT_VAL_W,
  parameter int K     = min_tracker_pkg::c_DEFAULT_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_index,
  input  logic [VAL_W-1:0]         in_value,
  input  logic                     in_last,
  input  logic [$clog2(K):0]       rd_sel,
  output logic [IDX_W-1:0]         rd_index,
  output logic [VAL_W-1:0]         rd_value,
  output logic [IDX_W-1:0]         best_index,
  output logic                     best_valid,
  output logic [$clog2(K+1)-1:0]   fill,
  output logic                     new_best,
  output logic                     done
);

  import min_tracker_pkg::*;

  localparam int FILL_W = $clog2(K+1);
  localparam int SEL_W  = $clog2(K) + 1;
  localparam logic [FILL_W-1:0] c_FULL = FILL_W'(K);

  trackerState_t     r_state;
  logic [VAL_W-1:0]  r_entryValue [K];
  logic [IDX_W-1:0]  r_entryIndex [K];
  logic [FILL_W-1:0] r_fill;
  logic              r_newBest;
  logic              r_done;

  logic [K*VAL_W-1:0] w_valuesFlat;
  logic [FILL_W-1:0]  w_insPos;
  logic               w_accept;
  logic               w_insert;

  for (genvar gi = 0; gi < K; gi++) begin : g_flatten
    assign w_valuesFlat[gi*VAL_W +: VAL_W] = r_entryValue[gi];
  end

  topk_insert_pos #(
    .VAL_W (VAL_W),
    .K     (K)
  ) u_insertPos (
    .entryValues (w_valuesFlat),
    .fill        (r_fill),
    .candValue   (in_value),
    .insPos      (w_insPos)
  );

  assign w_accept = (r_state == ST_SEARCH) && in_valid && !start;
  assign w_insert = w_accept && (w_insPos != c_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_fill    <= '0;
      r_newBest <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < K; i++) begin
        r_entryValue[i] <= '1;
        r_entryIndex[i] <= '0;
      end
    end else begin
      r_newBest <= 1'b0;
      r_done    <= 1'b0;
      if (start) begin
        r_state <= ST_SEARCH;
        r_fill  <= '0;
        for (int i = 0; i < K; i++) begin
          r_entryValue[i] <= '1;
          r_entryIndex[i] <= '0;
        end
      end else if (w_accept) begin
        if (w_insert) begin
          // Ranks below the insert point slide down; the old tail falls off.
          for (int i = 1; i < K; i++) begin
            if (FILL_W'(i) > w_insPos) begin
              r_entryValue[i] <= r_entryValue[i-1];
              r_entryIndex[i] <= r_entryIndex[i-1];
            end
          end
          for (int i = 0; i < K; i++) begin
            if (FILL_W'(i) == w_insPos) begin
              r_entryValue[i] <= in_value;
              r_entryIndex[i] <= in_index;
            end
          end
          r_fill    <= (r_fill == c_FULL) ? r_fill : r_fill + FILL_W'(1);
          r_newBest <= (w_insPos == '0);
        end
        r_done <= in_last;
        if (in_last) begin
          r_state <= ST_DONE;
        end
      end
    end
  end

  always_comb begin
    rd_index = '0;
    rd_value = '0;
    for (int i = 0; i < K; i++) begin
      if ((rd_sel == SEL_W'(i)) && (FILL_W'(i) < r_fill)) begin
        rd_index = r_entryIndex[i];
        rd_value = r_entryValue[i];
      end
    end
  end

  assign fill       = r_fill;
  assign best_valid = (r_fill != '0);
  assign best_index = r_entryIndex[0];
  assign new_best   = r_newBest;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_min_topk_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_min_topk_tracker : K=4 and K=1 trackers against a queue model      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_min_topk_tracker;

  localparam int IDX_W = 16;
  localparam int VAL_W = 14;
  localparam int K     = 4;
  localparam int ALL_ONES = (1 << VAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [IDX_W-1:0] in_index;
  logic [VAL_W-1:0] in_value;
  logic             in_last;

  logic [2:0]       rd_sel;
  logic [IDX_W-1:0] rd_index;
  logic [VAL_W-1:0] rd_value;
  logic [IDX_W-1:0] best_index;
  logic             best_valid;
  logic [2:0]       fill;
  logic             new_best;
  logic             done;

  logic [0:0]       rd_sel1;
  logic [IDX_W-1:0] rd_index1;
  logic [VAL_W-1:0] rd_value1;
  logic [IDX_W-1:0] best_index1;
  logic             best_valid1;
  logic [0:0]       fill1;
  logic             new_best1;
  logic             done1;

  always #5 clk = ~clk;

  min_topk_tracker #(.IDX_W(IDX_W), .VAL_W(VAL_W), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_index(in_index), .in_value(in_value), .in_last(in_last),
    .rd_sel(rd_sel), .rd_index(rd_index), .rd_value(rd_value),
    .best_index(best_index), .best_valid(best_valid), .fill(fill),
    .new_best(new_best), .done(done)
  );

  min_topk_tracker #(.IDX_W(IDX_W), .VAL_W(VAL_W), .K(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_index(in_index), .in_value(in_value), .in_last(in_last),
    .rd_sel(rd_sel1), .rd_index(rd_index1), .rd_value(rd_value1),
    .best_index(best_index1), .best_valid(best_valid1), .fill(fill1),
    .new_best(new_best1), .done(done1)
  );

  typedef struct {
    int idx;
    int val;
  } ent_t;

  ent_t q4[$];
  ent_t q1[$];
  int   mState;
  bit   expNb4;
  bit   expNb1;
  bit   expDone;
  int   nChecks;
  int   nFails;
  int   nbCount1;

  task automatic checkValue(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int insertPos(input ent_t q[$], input int v);
    int p = 0;
    foreach (q[i]) if (q[i].val < v) p++;
    return p;
  endfunction

  task automatic modelReset();
    q4.delete();
    q1.delete();
    mState  = 0;
    expNb4  = 0;
    expNb1  = 0;
    expDone = 0;
  endtask

  // One clock edge of the reference: sorted lists of the K lowest values, newest first on ties.
  task automatic modelStep(input bit s, input bit v, input bit l, input int idx, input int val);
    ent_t e;
    int   p;
    expNb4  = 0;
    expNb1  = 0;
    expDone = 0;
    e.idx = idx;
    e.val = val;
    if (s) begin
      q4.delete();
      q1.delete();
      mState = 1;
    end else if (mState == 1 && v) begin
      p = insertPos(q4, val);
      if (p < K) begin
        q4.insert(p, e);
        if (q4.size() > K) void'(q4.pop_back());
        expNb4 = (p == 0);
      end
      p = insertPos(q1, val);
      if (p < 1) begin
        q1.insert(p, e);
        if (q1.size() > 1) void'(q1.pop_back());
        expNb1 = 1;
      end
      expDone = l;
      if (l) mState = 2;
    end
  endtask

  task automatic checkAll();
    checkValue("fill", fill, q4.size());
    checkValue("best_valid", best_valid, q4.size() != 0);
    checkValue("best_index", best_index, (q4.size() != 0) ? q4[0].idx : 0);
    checkValue("new_best", new_best, expNb4);
    checkValue("done", done, expDone);
    checkValue("k1_fill", fill1, q1.size());
    checkValue("k1_best_index", best_index1, (q1.size() != 0) ? q1[0].idx : 0);
    checkValue("k1_new_best", new_best1, expNb1);
    checkValue("k1_done", done1, expDone);
    for (int s = 0; s < 5; s++) begin
      rd_sel = 3'(s);
      if (s < 2) rd_sel1 = 1'(s);
      #1;
      checkValue("rd_value", rd_value, (s < q4.size()) ? q4[s].val : 0);
      checkValue("rd_index", rd_index, (s < q4.size()) ? q4[s].idx : 0);
      if (s < 2) begin
        checkValue("k1_rd_value", rd_value1, (s < q1.size()) ? q1[s].val : 0);
      end
    end
  endtask

  task automatic cycle(input bit s, input bit v, input bit l, input int idx, input int val);
    start    = s;
    in_valid = v;
    in_last  = l;
    in_index = IDX_W'(idx);
    in_value = VAL_W'(val);
    @(posedge clk);
    modelStep(s, v, l, idx, val);
    #1;
    if (new_best1) nbCount1++;
    checkAll();
  endtask

  initial begin
    int expIdx [4];
    int expVal [4];
    nChecks  = 0;
    nFails   = 0;
    nbCount1 = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_index = '0;
    in_value = '0;
    rd_sel   = '0;
    rd_sel1  = '0;
    modelReset();
    #12;
    checkAll();
    rst = 1'b0;

    // Ties: the later 30 must outrank the earlier one.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 50);
    cycle(0, 1, 0, 1, 30);
    cycle(0, 1, 0, 2, 70);
    cycle(0, 1, 1, 3, 30);
    expIdx = '{3, 1, 0, 2};
    expVal = '{30, 30, 50, 70};
    for (int s = 0; s < 4; s++) begin
      rd_sel = 3'(s);
      #1;
      checkValue("rank_index", rd_index, expIdx[s]);
      checkValue("rank_value", rd_value, expVal[s]);
    end
    cycle(0, 0, 0, 0, 0);

    // Full list, then a loser and a new winner.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 10);
    cycle(0, 1, 0, 1, 20);
    cycle(0, 1, 0, 2, 30);
    cycle(0, 1, 0, 3, 40);
    cycle(0, 1, 0, 4, 100);
    cycle(0, 1, 0, 9, 5);
    checkValue("full_new_best", new_best, 1);

    // Asynchronous reset away from any clock edge.
    #1;
    rst    = 1'b1;
    rd_sel = '0;
    #1;
    modelReset();
    checkValue("arst_fill", fill, 0);
    checkValue("arst_best_valid", best_valid, 0);
    checkValue("arst_rd_value", rd_value, 0);
    checkValue("arst_best_index", best_index, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Start wins over a same-cycle candidate; DONE ignores candidates.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 5, 12);
    cycle(1, 1, 0, 7, 3);
    checkValue("restart_fill", fill, 0);
    cycle(0, 1, 1, 1, 8);
    cycle(0, 1, 0, 2, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 3, 9);
    checkValue("after_done_fill", fill, 1);

    // K=1 sequence: the second 4 takes rank 0.
    cycle(1, 0, 0, 0, 0);
    nbCount1 = 0;
    cycle(0, 1, 0, 0, 9);
    cycle(0, 1, 0, 1, 4);
    cycle(0, 1, 0, 2, 4);
    cycle(0, 1, 1, 3, 7);
    checkValue("k1_best_second4", best_index1, 2);
    checkValue("k1_nb_count", nbCount1, 3);

    for (int n = 0; n < 400; n++) begin
      bit s, v, l;
      int val;
      s   = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 11) == 0);
      val = ($urandom_range(0, 9) == 0) ? ALL_ONES : int'($urandom_range(0, 15));
      cycle(s, v, l, int'($urandom_range(0, 65535)), val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
